// File: rtl/input_feeder.sv
// ---------------------------------------------------------------------------
// input_feeder
//
// Frame-buffer responder for the processing unit's pixel-request interface.
// A host fills one INPUT_HEIGHT x INPUT_WIDTH frame through a valid/ready
// write port.  The frame is then served in raster order, one pixel per
// input_req, with a fixed response latency of RESP_LATENCY cycles.
//
// Handshakes:
//   Host write port:  a pixel is transferred on every rising edge where
//                     load_valid && load_ready.  load_ready is high only in
//                     the load phase.  load_valid is a plain strobe; the
//                     host may drop or change load_data on any cycle.
//   Request port:     input_req is sampled only in the serve phase.  A
//                     request accepted at edge N answers with a one-cycle
//                     input_ready pulse at edge N+RESP_LATENCY.  input_val
//                     carries the pixel for that pulse and then holds it.
//
// rewind restarts serving from pixel 0 (only from the idle serve or done
// phases, so an accepted request always completes).  clear discards the
// frame from any state and returns to the load phase.
//
// dbg_state exposes the controller state for checkers:
//   0 = LOAD, 1 = SERVE, 2 = WAIT, 3 = DONE.
// ---------------------------------------------------------------------------
module input_feeder #(
    parameter int BIN_LEN      = 8,
    parameter int INPUT_WIDTH  = 8,
    parameter int INPUT_HEIGHT = 8,
    parameter int RESP_LATENCY = 1,
    localparam int NPIX  = INPUT_WIDTH * INPUT_HEIGHT,
    localparam int PTR_W = (NPIX > 1) ? $clog2(NPIX) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load_valid,
    input  logic [BIN_LEN-1:0] load_data,
    output logic               load_ready,
    input  logic               clear,
    input  logic               rewind,
    input  logic               input_req,
    output logic [BIN_LEN-1:0] input_val,
    output logic               input_ready,
    output logic               frame_loaded,
    output logic               frame_done,
    output logic [PTR_W-1:0]   serve_index,
    output logic [1:0]         dbg_state
);

    // Latency countdown only needs to hold RESP_LATENCY-1.
    localparam int CNT_W = (RESP_LATENCY > 1) ? $clog2(RESP_LATENCY) : 1;

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NPIX - 1);
    localparam logic [CNT_W-1:0] LAT_M1   = CNT_W'(RESP_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SERVE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q,  state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [BIN_LEN-1:0] val_q,    val_d;
    logic               ready_q,  ready_d;
    logic               done_q,   done_d;
    logic               loaded_q, loaded_d;
    logic               buf_we;

    // Pixel storage; contents are meaningless until a full frame is loaded.
    logic [BIN_LEN-1:0] buf_q [NPIX];

    // Next-state, pointer and output computation for the controller.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        val_d    = val_q;
        ready_d  = 1'b0;
        done_d   = 1'b0;
        loaded_d = loaded_q;
        buf_we   = 1'b0;

        if (clear) begin
            // Flush: any outstanding request is dropped, a concurrent
            // host write is discarded.
            state_d  = ST_LOAD;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            val_d    = '0;
            loaded_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_LOAD: begin
                    if (load_valid) begin
                        buf_we = 1'b1;
                        if (wr_ptr_q == LAST_PTR) begin
                            // Last pixel of the frame: wrap and start serving.
                            wr_ptr_d = '0;
                            loaded_d = 1'b1;
                            state_d  = ST_SERVE;
                        end else begin
                            wr_ptr_d = wr_ptr_q + 1'b1;
                        end
                    end
                end

                ST_SERVE: begin
                    // rewind beats a same-cycle request.
                    if (rewind) begin
                        rd_ptr_d = '0;
                    end else if (input_req) begin
                        cnt_d   = LAT_M1;
                        state_d = ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        ready_d = 1'b1;
                        val_d   = buf_q[rd_ptr_q];
                        if (rd_ptr_q == LAST_PTR) begin
                            done_d   = 1'b1;
                            rd_ptr_d = '0;
                            state_d  = ST_DONE;
                        end else begin
                            rd_ptr_d = rd_ptr_q + 1'b1;
                            state_d  = ST_SERVE;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end

                ST_DONE: begin
                    // Requests are ignored until the frame is replayed.
                    if (rewind) begin
                        rd_ptr_d = '0;
                        state_d  = ST_SERVE;
                    end
                end

                default: begin
                    state_d = ST_LOAD;
                end
            endcase
        end
    end

    // Controller registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= ST_LOAD;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            val_q    <= '0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            val_q    <= val_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            loaded_q <= loaded_d;
        end
    end

    // Frame buffer write port; no reset since contents are don't-care.
    always_ff @(posedge clock) begin
        if (reset && buf_we) begin
            buf_q[wr_ptr_q] <= load_data;
        end
    end

    assign load_ready   = (state_q == ST_LOAD);
    assign input_val    = val_q;
    assign input_ready  = ready_q;
    assign frame_done   = done_q;
    assign frame_loaded = loaded_q;
    assign serve_index  = rd_ptr_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_input_feeder.sv
// ---------------------------------------------------------------------------
// tb_input_feeder
//
// Two instances (RESP_LATENCY 1 and 3, 4x4 frame) share one stimulus stream.
// A transaction-level model (frame array, serve pointer, pending response
// with an absolute due cycle) predicts every output; a negedge process
// compares both instances against it every cycle.  Directed checks with
// hand-computed literals pin the model along the way.
// ---------------------------------------------------------------------------
module tb_input_feeder;

    localparam int BIN_LEN = 8;
    localparam int W       = 4;
    localparam int H       = 4;
    localparam int NPIX    = W * H;
    localparam int PW      = 4;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // ---------------- clock / reset / inputs ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic               reset      = 1'b0;
    logic               load_valid = 1'b0;
    logic [BIN_LEN-1:0] load_data  = '0;
    logic               clear      = 1'b0;
    logic               rewind     = 1'b0;
    logic               input_req  = 1'b0;

    logic [BIN_LEN-1:0] val0, val1;
    logic               rdy0, rdy1, lr0, lr1, fl0, fl1, fd0, fd1;
    logic [PW-1:0]      idx0, idx1;
    logic [1:0]         st0, st1;

    input_feeder #(
        .BIN_LEN(BIN_LEN), .INPUT_WIDTH(W), .INPUT_HEIGHT(H), .RESP_LATENCY(1)
    ) u_dut_l1 (
        .clock(clock), .reset(reset),
        .load_valid(load_valid), .load_data(load_data), .load_ready(lr0),
        .clear(clear), .rewind(rewind), .input_req(input_req),
        .input_val(val0), .input_ready(rdy0),
        .frame_loaded(fl0), .frame_done(fd0),
        .serve_index(idx0), .dbg_state(st0)
    );

    input_feeder #(
        .BIN_LEN(BIN_LEN), .INPUT_WIDTH(W), .INPUT_HEIGHT(H), .RESP_LATENCY(3)
    ) u_dut_l3 (
        .clock(clock), .reset(reset),
        .load_valid(load_valid), .load_data(load_data), .load_ready(lr1),
        .clear(clear), .rewind(rewind), .input_req(input_req),
        .input_val(val1), .input_ready(rdy1),
        .frame_loaded(fl1), .frame_done(fd1),
        .serve_index(idx1), .dbg_state(st1)
    );

    logic [BIN_LEN-1:0] d_val [2];
    logic               d_rdy [2];
    logic               d_lr  [2];
    logic               d_fl  [2];
    logic               d_fd  [2];
    logic [PW-1:0]      d_idx [2];
    assign d_val[0] = val0; assign d_val[1] = val1;
    assign d_rdy[0] = rdy0; assign d_rdy[1] = rdy1;
    assign d_lr[0]  = lr0;  assign d_lr[1]  = lr1;
    assign d_fl[0]  = fl0;  assign d_fl[1]  = fl1;
    assign d_fd[0]  = fd0;  assign d_fd[1]  = fd1;
    assign d_idx[0] = idx0; assign d_idx[1] = idx1;

    // ---------------- scoreboard counters ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [BIN_LEN-1:0] m_frame [2][NPIX];
    int                 m_count [2];
    int                 m_next  [2];
    bit                 m_full  [2];
    bit                 m_pend  [2];
    bit                 m_fin   [2];
    longint             m_due   [2];
    longint             cyc = 0;
    logic [BIN_LEN-1:0] e_val   [2];
    bit                 e_rdy   [2];
    bit                 e_done  [2];

    always @(posedge clock) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            e_rdy[k]  = 1'b0;
            e_done[k] = 1'b0;
            if (!reset || clear) begin
                m_count[k] = 0;
                m_next[k]  = 0;
                m_full[k]  = 1'b0;
                m_pend[k]  = 1'b0;
                m_fin[k]   = 1'b0;
                e_val[k]   = '0;
            end else if (!m_full[k]) begin
                if (load_valid) begin
                    m_frame[k][m_count[k]] = load_data;
                    m_count[k]++;
                    if (m_count[k] == NPIX) begin
                        m_full[k]  = 1'b1;
                        m_count[k] = 0;
                    end
                end
            end else if (m_pend[k]) begin
                if (cyc == m_due[k]) begin
                    e_rdy[k]  = 1'b1;
                    e_val[k]  = m_frame[k][m_next[k]];
                    m_pend[k] = 1'b0;
                    if (m_next[k] == NPIX - 1) begin
                        e_done[k] = 1'b1;
                        m_next[k] = 0;
                        m_fin[k]  = 1'b1;
                    end else begin
                        m_next[k]++;
                    end
                end
            end else if (m_fin[k]) begin
                if (rewind) begin
                    m_fin[k]  = 1'b0;
                    m_next[k] = 0;
                end
            end else if (rewind) begin
                m_next[k] = 0;
            end else if (input_req) begin
                m_pend[k] = 1'b1;
                m_due[k]  = cyc + lat_of(k);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("L%0d input_ready", lat_of(k)), 32'(d_rdy[k]), 32'(e_rdy[k]));
                chk($sformatf("L%0d input_val", lat_of(k)), 32'(d_val[k]), 32'(e_val[k]));
                chk($sformatf("L%0d frame_done", lat_of(k)), 32'(d_fd[k]), 32'(e_done[k]));
                chk($sformatf("L%0d frame_loaded", lat_of(k)), 32'(d_fl[k]), 32'(m_full[k]));
                chk($sformatf("L%0d load_ready", lat_of(k)), 32'(d_lr[k]), 32'(!m_full[k]));
                chk($sformatf("L%0d serve_index", lat_of(k)), 32'(d_idx[k]), 32'(m_next[k]));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(negedge clock);
    endtask

    int p0, p1;
    logic [BIN_LEN-1:0] last_val1;

    initial begin
        // Reset for two cycles.
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst load_ready", 32'(lr0), 32'd1);
        chk("rst input_ready", 32'(rdy0), 32'd0);
        chk("rst frame_loaded", 32'(fl0), 32'd0);
        chk("rst input_val", 32'(val0), 32'd0);
        chk("rst serve_index", 32'(idx1), 32'd0);

        // Load 0..15 -> value index+3, with input_req held (must be ignored).
        reset     = 1'b1;
        input_req = 1'b1;
        for (int i = 0; i < NPIX; i++) begin
            load_valid = 1'b1;
            load_data  = BIN_LEN'(i + 3);
            tick();
            if (i == NPIX - 2) chk("load fl before last", 32'(fl0), 32'd0);
        end
        load_valid = 1'b0;
        input_req  = 1'b0;
        chk("load frame_loaded", 32'(fl0), 32'd1);
        chk("load load_ready", 32'(lr0), 32'd0);
        chk("load L3 frame_loaded", 32'(fl1), 32'd1);
        tick();

        // Single request.
        input_req = 1'b1;
        tick();
        input_req = 1'b0;
        chk("single no early pulse", 32'(rdy0), 32'd0);
        tick();
        chk("single input_ready", 32'(rdy0), 32'd1);
        chk("single input_val", 32'(val0), 32'd3);
        chk("single serve_index", 32'(idx0), 32'd1);
        repeat (6) tick();

        // Host writes in SERVE must not touch the buffer.
        load_valid = 1'b1;
        load_data  = 8'hEE;
        repeat (3) tick();
        load_valid = 1'b0;

        // Rewind in SERVE, then hold requests through the whole frame.
        rewind = 1'b1;
        tick();
        rewind = 1'b0;
        chk("rewind serve idx L1", 32'(idx0), 32'd0);
        chk("rewind serve idx L3", 32'(idx1), 32'd0);
        input_req = 1'b1;
        p0 = 0;
        p1 = 0;
        last_val1 = '0;
        for (int c = 0; c < 70; c++) begin
            tick();
            if (rdy0) p0++;
            if (rdy1) begin
                p1++;
                if (fd1) last_val1 = val1;
            end
        end
        input_req = 1'b0;
        chk("held L1 pulses", 32'(p0), 32'd16);
        chk("held L3 pulses", 32'(p1), 32'd16);
        chk("held L3 done value", 32'(last_val1), 32'd18);

        // Rewind with a same-cycle request in DONE: rewind wins, no pulse.
        rewind    = 1'b1;
        input_req = 1'b1;
        tick();
        rewind    = 1'b0;
        input_req = 1'b0;
        chk("done rewind idx", 32'(idx0), 32'd0);
        tick();
        chk("done rewind no pulse", 32'(rdy0), 32'd0);
        input_req = 1'b1;
        tick();
        input_req = 1'b0;
        tick();
        chk("replay input_ready", 32'(rdy0), 32'd1);
        chk("replay input_val", 32'(val0), 32'd3);
        repeat (5) tick();

        // Clear during WAIT, with a discarded host write in the same cycle.
        input_req = 1'b1;
        tick();
        input_req  = 1'b0;
        clear      = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'h55;
        tick();
        clear      = 1'b0;
        load_valid = 1'b0;
        chk("clear no pulse L1", 32'(rdy0), 32'd0);
        chk("clear frame_loaded", 32'(fl0), 32'd0);
        chk("clear load_ready", 32'(lr0), 32'd1);
        chk("clear input_val", 32'(val0), 32'd0);
        repeat (4) tick();

        // Reload 100..115 and request the first pixel.
        for (int i = 0; i < NPIX; i++) begin
            load_valid = 1'b1;
            load_data  = BIN_LEN'(100 + i);
            tick();
        end
        load_valid = 1'b0;
        tick();
        input_req = 1'b1;
        tick();
        input_req = 1'b0;
        tick();
        chk("reload input_ready", 32'(rdy0), 32'd1);
        chk("reload input_val", 32'(val0), 32'd100);
        repeat (5) tick();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/input_feeder.md
Name: input_feeder

Overview:
- Frame-buffer responder for the processing unit's pixel-request interface. It answers the processing unit's input_req with input_val / input_ready.
- A host loads one INPUT_HEIGHT x INPUT_WIDTH frame of binary pixels through a valid/ready write port.
- The block then serves the pixels in raster order, row-major, one pixel per request, with a fixed response latency.
- It supports rewind, which replays the same frame for another kernel pass, and clear, which discards the frame so a new one can be loaded.

Parameters:
- BIN_LEN, 8, pixel width in bits (same as the `BIN_LEN define).
- INPUT_WIDTH, 8, frame width in pixels.
- INPUT_HEIGHT, 8, frame height in pixels.
- RESP_LATENCY, 1, cycles from request acceptance to the input_ready pulse; must be >= 1.
- Derived: NPIX = INPUT_WIDTH*INPUT_HEIGHT; PTR_W = clog2(NPIX).

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- load_valid  in  1  host write strobe.
- load_data  in  BIN_LEN  host pixel data.
- load_ready  out  1  block can accept a host pixel.
- clear  in  1  synchronous flush back to the load phase.
- rewind  in  1  restart serving from pixel 0.
- input_req  in  1  pixel request from the processing unit.
- input_val  out  BIN_LEN  served pixel value.
- input_ready  out  1  one-cycle pulse: input_val is valid.
- frame_loaded  out  1  level, high while a complete frame is held.
- frame_done  out  1  one-cycle pulse, coincident with the input_ready of the last pixel.
- serve_index  out  PTR_W  index of the next pixel to be served.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=LOAD, wr_ptr=0, rd_ptr=0, latency counter=0.
  - Outputs: input_val=0, input_ready=0, frame_done=0, frame_loaded=0, load_ready=1, serve_index=0.
  - Buffer contents are don't-care.
- State LOAD:
  - load_ready=1.
  - On load_valid&&load_ready: write buf[wr_ptr]=load_data, then wr_ptr++.
  - The write at wr_ptr==NPIX-1 sets wr_ptr=0 and frame_loaded=1, and moves to SERVE on the next cycle.
  - input_req is ignored in LOAD: no input_ready is ever produced.
- State SERVE:
  - load_ready=0.
  - If input_req==1 and rewind==0: accept the request, latch rd_ptr, load counter=RESP_LATENCY-1, go to WAIT.
- State WAIT:
  - Counter decrements each cycle.
  - On the cycle the counter reads 0:
    - input_ready=1 and input_val=buf[rd_ptr].
    - rd_ptr++.
    - If rd_ptr was NPIX-1: frame_done=1, rd_ptr=0, go to DONE. Otherwise go to SERVE.
  - Latency: a request accepted at edge N produces input_ready at edge N+RESP_LATENCY.
  - input_req is not sampled in WAIT.
- Request hold:
  - If input_req stays high through input_ready, the next request is accepted on the cycle after the pulse.
  - Maximum throughput is therefore one pixel per RESP_LATENCY+1 cycles.
- input_val holds its last served value between pulses. It changes only on an input_ready cycle, or on reset/clear.
- State DONE:
  - input_req is ignored.
  - frame_loaded stays 1.
  - rewind==1 -> SERVE with rd_ptr=0.
- rewind:
  - Honoured only in SERVE or DONE; sets rd_ptr=0.
  - Ignored in LOAD and WAIT, so an outstanding request always completes.
  - rewind and input_req in the same SERVE cycle: rewind wins and the request is not accepted that cycle.
- clear:
  - Highest priority after reset; acts from any state.
  - Next state is LOAD with wr_ptr=rd_ptr=0, frame_loaded=0, input_val=0.
  - An outstanding WAIT request is dropped and produces no input_ready.
  - A load_valid in the same cycle as clear is discarded.
- serve_index equals rd_ptr (registered).
- Pointers wrap exactly at NPIX, so non-power-of-two frames are supported; no pointer ever reaches NPIX.
- input_ready and frame_done are registered outputs and are never asserted in LOAD.

Test Plan:
- Reset and load: with W=H=4 and RESP_LATENCY=1, hold reset low for 2 cycles; expect load_ready=1 and all other outputs 0. Write pixels 0..15 with value=index+3 and load_valid always high; frame_loaded rises the cycle after the 16th write and load_ready then drops.
- Single request: raise input_req for 1 cycle in SERVE; expect input_ready exactly 1 cycle later with input_val=3, and serve_index then reads 1.
- Latency parameter: with RESP_LATENCY=3 and input_req held high, expect input_ready on every 4th cycle with values 3,4,5,...; after 16 pulses frame_done=1 coincides with input_val=18; further requests produce no pulses.
- Rewind: in DONE, assert rewind and input_req together; rewind is taken and there is no pulse. The next request returns input_val=3 with serve_index=0 before the pulse.
- Clear mid-request: accept a request, then assert clear during WAIT. Expect no input_ready, frame_loaded=0, load_ready=1, and input_val=0. Reload the frame with values 100..115; the first request returns 100.
- Ignored traffic: input_req held high throughout LOAD gives no input_ready. Asserting load_valid in SERVE does not alter the buffer; verify by serving all 16 pixels, which must match the loaded values.
